// File: rtl/controller_tx_arbiter.sv
// ---------------------------------------------------------------------------
// controller_tx_arbiter
//
// Shares the single host-facing UART transmit pin between the player 1 and
// player 2 controller channels. A round-robin arbiter picks one pending
// request, acknowledges it with a one-cycle pulse, and the byte is then sent
// as a standard 8N1 frame (start bit, 8 data bits LSB first, stop bit).
//
// Optional build macro: TX_TAG_EN
//   When defined, every grant sends two back-to-back frames: a channel tag
//   byte (TAG1 / TAG2) followed by the data byte, with no idle gap between.
//   When undefined, only the data frame is sent and TAG1/TAG2 are unused.
//
// Parameters:
//   CLK_DIV  clk cycles per serial bit (2..65535)
//   TAG1     channel 1 tag byte (TX_TAG_EN only)
//   TAG2     channel 2 tag byte (TX_TAG_EN only)
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   req1   channel 1 request, held with data1 stable until ack1
//   data1  channel 1 byte
//   ack1   one-cycle pulse, data1 has been captured
//   req2   channel 2 request
//   data2  channel 2 byte
//   ack2   one-cycle pulse, data2 has been captured
//   txd    serial output, idle high
//   busy   high whenever the transmitter is not idle
// ---------------------------------------------------------------------------
module controller_tx_arbiter #(
    parameter int unsigned CLK_DIV = 16,
    parameter logic [7:0]  TAG1    = 8'hA1,
    parameter logic [7:0]  TAG2    = 8'hA2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    input  logic       req2,
    input  logic [7:0] data2,
    output logic       ack2,
    output logic       txd,
    output logic       busy
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

`ifdef TX_TAG_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, TAG_START, TAG_DATA, TAG_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, START, DATA, STOP
    } state_t;
`endif

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        ptr_ch2;
    logic        gnt1;
    logic        gnt2;
    logic        grant_slot;
    logic        baud_last;

`ifdef TX_TAG_EN
    logic [7:0]  data_hold;
`else
    // Tag bytes only matter when tagging is compiled in.
    logic        unused_tags;
    assign unused_tags = ^{TAG1, TAG2};
`endif

    // Arbitration decision. A grant may be issued either from a quiet IDLE
    // cycle or from the final STOP cycle, so that the ack lands in the single
    // IDLE cycle that separates back-to-back frames.
    always_comb begin
        baud_last  = (baud_cnt == BAUD_LAST);
        gnt1       = req1 && (!req2 || !ptr_ch2);
        gnt2       = req2 && (!req1 || ptr_ch2);
        grant_slot = ((state == IDLE) && !ack1 && !ack2) ||
                     ((state == STOP) && baud_last);
    end

    // Transmitter FSM with registered outputs. The ack pulse marks the IDLE
    // cycle in which data was captured; the frame starts on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ptr_ch2   <= 1'b0;
            ack1      <= 1'b0;
            ack2      <= 1'b0;
            txd       <= 1'b1;
            busy      <= 1'b0;
`ifdef TX_TAG_EN
            data_hold <= '0;
`endif
        end else begin
            ack1 <= 1'b0;
            ack2 <= 1'b0;

            if (grant_slot && gnt1) begin
                ack1    <= 1'b1;
                ptr_ch2 <= 1'b1;
`ifdef TX_TAG_EN
                shift_reg <= TAG1;
                data_hold <= data1;
`else
                shift_reg <= data1;
`endif
            end else if (grant_slot && gnt2) begin
                ack2    <= 1'b1;
                ptr_ch2 <= 1'b0;
`ifdef TX_TAG_EN
                shift_reg <= TAG2;
                data_hold <= data2;
`else
                shift_reg <= data2;
`endif
            end

            case (state)
                IDLE: begin
                    if (ack1 || ack2) begin
`ifdef TX_TAG_EN
                        state <= TAG_START;
`else
                        state <= START;
`endif
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                    end
                end

                START: begin
                    if (baud_last) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                // The shift register always presents the current bit at [0],
                // so the next bit to drive is at [1] before shifting.
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            txd       <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

`ifdef TX_TAG_EN
                TAG_START: begin
                    if (baud_last) begin
                        state    <= TAG_DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                TAG_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= TAG_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            txd       <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                // The tag frame chains straight into the data frame's start
                // bit without passing through IDLE.
                TAG_STOP: begin
                    if (baud_last) begin
                        state     <= START;
                        baud_cnt  <= '0;
                        txd       <= 1'b0;
                        shift_reg <= data_hold;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_controller_tx_arbiter
//
// Directed, table-driven bench for controller_tx_arbiter at CLK_DIV=4.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge. When built with TX_TAG_EN the expected serial stream includes the
// channel tag frame ahead of each data frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_controller_tx_arbiter;

    localparam int CLK_DIV = 4;
    localparam int FRAME1  = 10 * CLK_DIV;
`ifdef TX_TAG_EN
    localparam int N_FRAMES = 2;
`else
    localparam int N_FRAMES = 1;
`endif
    localparam int FRAME_CYC   = FRAME1 * N_FRAMES;
    localparam int ACK_TIMEOUT = 200;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req1  = 1'b0;
    logic       req2  = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic       ack1;
    logic       ack2;
    logic       txd;
    logic       busy;

    int   check_count = 0;
    int   error_count = 0;
    logic both_seen   = 1'b0;
    logic busy_at_ack = 1'b0;

    typedef struct {
        logic       r1;
        logic [7:0] d1;
        logic       r2;
        logic [7:0] d2;
        int         exp_ch;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [8];

    controller_tx_arbiter #(
        .CLK_DIV (CLK_DIV),
        .TAG1    (8'hA1),
        .TAG2    (8'hA2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req1  (req1),
        .data1 (data1),
        .ack1  (ack1),
        .req2  (req2),
        .data2 (data2),
        .ack2  (ack2),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [79:0] actual,
                               input logic [79:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req1  = v.r1;
        data1 = v.d1;
        req2  = v.r2;
        data2 = v.d2;
    endtask

    // Expected txd samples, one per clock, for a grant of channel ch.
    function automatic logic [79:0] expect_samples(input int ch, input logic [7:0] b);
        logic [79:0] s;
        logic [9:0]  fr;
        logic [7:0]  bb;
        s = '0;
        for (int f = 0; f < N_FRAMES; f++) begin
            if (N_FRAMES == 2 && f == 0) bb = (ch == 1) ? 8'hA1 : 8'hA2;
            else                         bb = b;
            fr = {1'b1, bb, 1'b0};
            for (int k = 0; k < 10; k++)
                for (int j = 0; j < CLK_DIV; j++)
                    s[f * FRAME1 + k * CLK_DIV + j] = fr[k];
        end
        return s;
    endfunction

    task automatic wait_ack(output int ch, output int cycles);
        ch = 0;
        cycles = 0;
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            @(negedge clk);
            cycles++;
            if (ack1 && ack2) both_seen = 1'b1;
            if (ack1 || ack2) begin
                ch = ack1 ? 1 : 2;
                busy_at_ack = busy;
                break;
            end
        end
    endtask

    task automatic capture(output logic [79:0] smp, output logic busy_ok,
                           output logic extra_ack);
        smp = '0;
        busy_ok = 1'b1;
        extra_ack = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            smp[i] = txd;
            if (!busy) busy_ok = 1'b0;
            if (ack1 || ack2) extra_ack = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req1 = 1'b0;
        req2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One grant from idle: check the winner, the serial stream and busy.
    task automatic run_vector(input vec_t v, input string name);
        int          ch;
        int          cyc;
        logic [79:0] smp;
        logic        bok;
        logic        xa;
        applyStimulus(v);
        wait_ack(ch, cyc);
        req1 = 1'b0;
        req2 = 1'b0;
        checkOutput({name, " grant"}, 80'(ch), 80'(v.exp_ch));
        checkOutput({name, " busy at ack"}, 80'(busy_at_ack), 80'(0));
        capture(smp, bok, xa);
        checkOutput({name, " frame"}, smp, expect_samples(v.exp_ch, v.exp_byte));
        checkOutput({name, " busy in frame"}, 80'(bok), 80'(1));
    endtask

    initial begin
        int          ch;
        int          cyc;
        logic [79:0] smp;
        logic        bok;
        logic        xa;
        logic [9:0]  pat;
        logic [39:0] exp40;
        logic [39:0] got40;
        int          busy_cycles;
        logic        saw_ack2;

        // Directed vectors; pointer starts on channel 1 after reset and
        // flips to the other channel after each grant.
        vecs[0] = '{1'b1, 8'h35, 1'b0, 8'h00, 1, 8'h35};
        vecs[1] = '{1'b1, 8'hC3, 1'b1, 8'h3C, 2, 8'h3C};
        vecs[2] = '{1'b1, 8'h00, 1'b1, 8'hFF, 1, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'hFF, 2, 8'hFF};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h81, 2, 8'h81};
        vecs[5] = '{1'b1, 8'hA5, 1'b1, 8'h5A, 1, 8'hA5};
        vecs[6] = '{1'b1, 8'h7E, 1'b0, 8'h00, 1, 8'h7E};
        vecs[7] = '{1'b1, 8'h01, 1'b1, 8'h80, 2, 8'h80};

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset txd",  80'(txd),  80'(1));
        checkOutput("reset busy", 80'(busy), 80'(0));
        checkOutput("reset ack1", 80'(ack1), 80'(0));
        checkOutput("reset ack2", 80'(ack2), 80'(0));
        rst_n = 1'b1;

        // Single byte 0x35 on channel 1, literal bit pattern
        req1 = 1'b1;
        data1 = 8'h35;
        wait_ack(ch, cyc);
        req1 = 1'b0;
        checkOutput("t1 grant", 80'(ch), 80'(1));
        capture(smp, bok, xa);
        checkOutput("t1 ack pulse single", 80'(xa), 80'(0));
        pat = 10'b1001101010;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CLK_DIV; j++)
                exp40[k * CLK_DIV + j] = pat[k];
        for (int i = 0; i < FRAME1; i++) got40[i] = smp[(N_FRAMES - 1) * FRAME1 + i];
        checkOutput("t1 txd pattern", 80'(got40), 80'(exp40));
        checkOutput("t1 busy in frame", 80'(bok), 80'(1));
        @(negedge clk);
        checkOutput("t1 busy after frame", 80'(busy), 80'(0));
        checkOutput("t1 txd idle", 80'(txd), 80'(1));

        // Simultaneous requests from reset: ch1 first, ch2 one frame later
        do_reset();
        req1 = 1'b1; data1 = 8'h11;
        req2 = 1'b1; data2 = 8'h22;
        wait_ack(ch, cyc);
        req1 = 1'b0;
        checkOutput("sim first grant", 80'(ch), 80'(1));
        capture(smp, bok, xa);
        checkOutput("sim first frame", smp, expect_samples(1, 8'h11));
        checkOutput("sim no ack in frame", 80'(xa), 80'(0));
        wait_ack(ch, cyc);
        req2 = 1'b0;
        checkOutput("sim second grant", 80'(ch), 80'(2));
        checkOutput("sim ack spacing", 80'(cyc), 80'(1));
        capture(smp, bok, xa);
        checkOutput("sim second frame", smp, expect_samples(2, 8'h22));
        checkOutput("sim acks never together", 80'(both_seen), 80'(0));

        // Continuous requests: grants alternate 1,2,1,2,1,2
        req1 = 1'b1; data1 = 8'hC1;
        req2 = 1'b1; data2 = 8'hC2;
        for (int g = 0; g < 6; g++) begin
            wait_ack(ch, cyc);
            checkOutput($sformatf("fair grant %0d", g), 80'(ch), 80'((g % 2 == 0) ? 1 : 2));
            checkOutput($sformatf("fair spacing %0d", g), 80'(cyc), 80'(1));
            capture(smp, bok, xa);
            checkOutput($sformatf("fair frame %0d", g), smp,
                        expect_samples((g % 2 == 0) ? 1 : 2, (g % 2 == 0) ? 8'hC1 : 8'hC2));
        end
        req1 = 1'b0;
        req2 = 1'b0;
        checkOutput("fair acks never together", 80'(both_seen), 80'(0));

        // Table of single grants from idle
        do_reset();
        for (int i = 0; i < 8; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of the data bits, with channel 2 pending
        req1 = 1'b1; data1 = 8'hF0;
        wait_ack(ch, cyc);
        req1 = 1'b0;
        req2 = 1'b1; data2 = 8'h96;
        checkOutput("abort grant", 80'(ch), 80'(1));
        repeat (14) @(negedge clk);
        checkOutput("abort txd before reset", 80'(txd), 80'(0));
        rst_n = 1'b0;
        #1;
        checkOutput("abort txd", 80'(txd), 80'(1));
        checkOutput("abort busy", 80'(busy), 80'(0));
        checkOutput("abort ack2", 80'(ack2), 80'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ack(ch, cyc);
        req2 = 1'b0;
        checkOutput("abort pending grant", 80'(ch), 80'(2));
        checkOutput("abort pending latency", 80'(cyc), 80'(1));
        capture(smp, bok, xa);
        checkOutput("abort pending frame", smp, expect_samples(2, 8'h96));

        // Short req2 pulse during a channel 1 frame is lost
        req1 = 1'b1; data1 = 8'hC5;
        wait_ack(ch, cyc);
        req1 = 1'b0;
        checkOutput("pulse grant", 80'(ch), 80'(1));
        repeat (10) @(negedge clk);
        req2 = 1'b1; data2 = 8'h77;
        @(negedge clk);
        req2 = 1'b0;
        busy_cycles = 0;
        saw_ack2 = 1'b0;
        for (int i = 0; i < FRAME_CYC + 20; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (ack2) saw_ack2 = 1'b1;
        end
        checkOutput("pulse no ack2", 80'(saw_ack2), 80'(0));
        checkOutput("pulse busy cycles", 80'(busy_cycles), 80'(FRAME_CYC - 11));

`ifdef TX_TAG_EN
        // Tagged grant: A2 frame then 5A frame, one ack2
        req2 = 1'b1; data2 = 8'h5A;
        wait_ack(ch, cyc);
        req2 = 1'b0;
        checkOutput("tag grant", 80'(ch), 80'(2));
        capture(smp, bok, xa);
        checkOutput("tag frames", smp, expect_samples(2, 8'h5A));
        checkOutput("tag single ack", 80'(xa), 80'(0));
        checkOutput("tag busy 80 cycles", 80'(bok), 80'(1));
        @(negedge clk);
        checkOutput("tag busy after", 80'(busy), 80'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
